gb_ram_ctrl: RTL
================

// Module: gb_ram_ctrl
// PURPOSE
// Frame sequencer and RAM-port arbiter for the gray-balance histogram-occupancy RAM: a 1-bit-per-level RAM of
// 2**DATA_WIDTH entries. It gates the input stream and routes the level-statistics unit's write strobes to the
// RAM while a frame is active. After each frame it sweeps every RAM entry back to 0, so the next frame starts
// from an empty occupancy map. It sits between the video input, the stat unit and the single-port-write RAM.
// PARAMETERS
// DATA_WIDTH  14  pixel/gray-level width; RAM depth = 2**DATA_WIDTH
// PIPE_DELAY  2   cycles from din beat to the stat unit's aft beat (write drain time after din EOP)
// FCNT_WIDTH  16  width of frame_cnt
// PORTS
// clk                input   1              system clock
// rst_n              input   1              asynchronous active-low reset
// din_valid          input   1              input stream beat valid
// din_startofpacket  input   1              first beat of frame
// din_endofpacket    input   1              last beat of frame
// din_ready          output  1              stream accept; beat transfers when din_valid & din_ready
// stat_write         input   1              write strobe from stat unit (marks level present)
// stat_addr          input   DATA_WIDTH     gray level to mark
// ram_addr           output  DATA_WIDTH     RAM write address
// ram_wdata          output  1              RAM write data
// ram_we             output  1              RAM write enable
// clear_busy         output  1              high while sweeping the RAM
// frame_done         output  1              1-cycle pulse: frame stats complete, stat_cnt valid
// frame_err          output  1              1-cycle pulse: SOP seen mid-frame, frame aborted
// frame_cnt          output  FCNT_WIDTH     completed-frame count, wraps
// BEHAVIOUR
// - One clock; reset asynchronous, active-low. All outputs are registered.
// - Reset values: state=INIT_CLR, din_ready=0, ram_we=0, ram_addr=0, ram_wdata=0, clear_busy=0,
//   frame_done=0, frame_err=0, frame_cnt=0.
// - States: INIT_CLR -> IDLE -> STAT -> DRAIN -> CLEAR -> IDLE.
// - INIT_CLR/CLEAR: clr_addr counts 0..2**DATA_WIDTH-1, one address per cycle; ram_we=1, ram_wdata=0,
//   ram_addr=clr_addr; clear_busy=1; din_ready=0. After the last address, go to IDLE next cycle.
//   A sweep takes exactly 2**DATA_WIDTH cycles; clr_addr resets to 0 on entry.
// - IDLE: din_ready=1, ram_we=0. Accepted beat with SOP -> STAT; SOP&EOP on the same beat -> DRAIN.
//   Accepted non-SOP beats are discarded (no state change).
// - STAT: din_ready=1; ram_addr<=stat_addr, ram_we<=stat_write, ram_wdata<=1 (1-cycle latency).
//   Accepted beat with EOP -> DRAIN. Accepted beat with SOP and no EOP -> frame_err pulse, DRAIN; the frame is
//   aborted, frame_done is not pulsed for it, and frame_cnt is not incremented.
// - DRAIN: din_ready=0; continue forwarding stat_write/stat_addr as in STAT for PIPE_DELAY+1 cycles. On exit:
//   frame_done pulse (unless aborted), frame_cnt+1 (unless aborted), go to CLEAR.
// - A stat_write arriving outside STAT/DRAIN is ignored: it is never forwarded.
// - Reset mid-sweep or mid-frame: restart in INIT_CLR. RAM contents are treated as unknown.
// - frame_cnt wraps from 2**FCNT_WIDTH-1 to 0.
// STRUCTURE
// - Shared package gb_pkg: state enum encoding (INIT_CLR, IDLE, STAT, DRAIN, CLEAR) and the DATA_WIDTH default.
// - One sub-module: gb_clr_sweep (address counter with start/busy/last outputs), used by INIT_CLR and CLEAR.
//   The FSM and the RAM-port mux stay in this module.
// TESTING (DATA_WIDTH=4, PIPE_DELAY=2)
// 1. Release reset -> ram_we=1 for 16 cycles, ram_addr 0..15, wdata=0; then din_ready=1, clear_busy=0.
// 2. 8-beat frame (SOP beat 0, EOP beat 7), stat_write on levels 3,5,9 -> ram_we/addr 3,5,9 at +1 cycle,
//    wdata=1; din_ready=0 for 3 DRAIN cycles; frame_done pulse; frame_cnt=1; 16-cycle clear follows.
// 3. Single-beat frame (SOP&EOP) -> IDLE directly to DRAIN; frame_done after 3 cycles; then clear.
// 4. Second SOP at beat 4 of a frame -> frame_err pulse, no frame_done, frame_cnt unchanged, clear runs.
// 5. din_valid held high during CLEAR -> din_ready=0 throughout; no beats accepted. stat_write pulsed in IDLE
//    -> ram_we stays 0.
// 6. Assert rst_n=0 at clear address 7 -> outputs return to reset values; sweep restarts at address 0.

Source files
------------

// File: rtl/gb_pkg.sv
// Shared encodings for the gray-balance occupancy RAM controller: FSM states,
// the default level width and small state-class helpers.
package gb_pkg;

    localparam int GB_DATA_WIDTH = 14;

    localparam logic [2:0] ST_INIT_CLR = 3'd0;
    localparam logic [2:0] ST_IDLE     = 3'd1;
    localparam logic [2:0] ST_STAT     = 3'd2;
    localparam logic [2:0] ST_DRAIN    = 3'd3;
    localparam logic [2:0] ST_CLEAR    = 3'd4;

    function automatic logic is_sweep(input logic [2:0] st);
        return (st == ST_INIT_CLR) || (st == ST_CLEAR);
    endfunction

    function automatic logic is_fwd(input logic [2:0] st);
        return (st == ST_STAT) || (st == ST_DRAIN);
    endfunction

endpackage

// File: rtl/gb_clr_sweep.sv
// RAM clear sweep: walks addresses 0..2**AW-1, one per cycle, starting out of
// reset or on start_i; last_o flags the final address of the pass.
module gb_clr_sweep
    import gb_pkg::*;
#(
    parameter int AW = GB_DATA_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    output logic [AW-1:0] addr_o,
    output logic          busy_o,
    output logic          last_o
);

    logic [AW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;

    // next address and busy flag; a pass ends by wrapping the counter back to 0
    always_comb begin
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start_i) begin
            cnt_d  = {AW{1'b0}};
            busy_d = 1'b1;
        end else if (busy_q) begin
            cnt_d = cnt_q + AW'(1'b1);
            if (cnt_q == {AW{1'b1}}) begin
                busy_d = 1'b0;
            end else begin
                busy_d = 1'b1;
            end
        end else begin
            cnt_d  = cnt_q;
            busy_d = 1'b0;
        end
    end

    // sweep state; a reset always leaves a pass pending so RAM is rebuilt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= {AW{1'b0}};
            busy_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign addr_o = cnt_q;
    assign busy_o = busy_q;
    assign last_o = busy_q & (cnt_q == {AW{1'b1}});

endmodule

// File: rtl/gb_ram_ctrl.sv
// Frame sequencer and RAM write-port arbiter for the occupancy RAM: forwards
// stat-unit marks during a frame, then sweeps the RAM back to zero.
module gb_ram_ctrl
    import gb_pkg::*;
#(
    parameter int DATA_WIDTH = GB_DATA_WIDTH,
    parameter int PIPE_DELAY = 2,
    parameter int FCNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  din_valid,
    input  logic                  din_startofpacket,
    input  logic                  din_endofpacket,
    output logic                  din_ready,
    input  logic                  stat_write,
    input  logic [DATA_WIDTH-1:0] stat_addr,
    output logic [DATA_WIDTH-1:0] ram_addr,
    output logic                  ram_wdata,
    output logic                  ram_we,
    output logic                  clear_busy,
    output logic                  frame_done,
    output logic                  frame_err,
    output logic [FCNT_WIDTH-1:0] frame_cnt
);

    localparam int DCW = $clog2(PIPE_DELAY + 2);

    logic [2:0]            state_q, state_d;
    logic [DCW-1:0]        drain_cnt_q, drain_cnt_d;
    logic                  aborted_q, aborted_d;
    logic                  din_ready_q, din_ready_d;
    logic                  ram_we_q, ram_we_d;
    logic                  ram_wdata_q, ram_wdata_d;
    logic [DATA_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic                  clear_busy_q, clear_busy_d;
    logic                  frame_done_q, frame_done_d;
    logic                  frame_err_q, frame_err_d;
    logic [FCNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;

    logic                  accept_s;
    logic                  sweep_start_s;
    logic                  clr_busy_s;
    logic                  clr_last_s;
    logic [DATA_WIDTH-1:0] clr_addr_s;

    assign accept_s = din_valid & din_ready_q;

    gb_clr_sweep #(
        .AW (DATA_WIDTH)
    ) u_sweep (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (sweep_start_s),
        .addr_o  (clr_addr_s),
        .busy_o  (clr_busy_s),
        .last_o  (clr_last_s)
    );

    // frame sequencing; an aborted frame still drains but is not counted
    always_comb begin
        state_d       = state_q;
        drain_cnt_d   = drain_cnt_q;
        aborted_d     = aborted_q;
        frame_done_d  = 1'b0;
        frame_err_d   = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        sweep_start_s = 1'b0;
        case (state_q)
            ST_INIT_CLR, ST_CLEAR: begin
                if (clr_last_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            ST_IDLE: begin
                if (accept_s && din_startofpacket) begin
                    drain_cnt_d = {DCW{1'b0}};
                    aborted_d   = 1'b0;
                    if (din_endofpacket) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_STAT;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_STAT: begin
                if (accept_s && din_startofpacket && !din_endofpacket) begin
                    frame_err_d = 1'b1;
                    aborted_d   = 1'b1;
                    drain_cnt_d = {DCW{1'b0}};
                    state_d     = ST_DRAIN;
                end else if (accept_s && din_endofpacket) begin
                    drain_cnt_d = {DCW{1'b0}};
                    state_d     = ST_DRAIN;
                end else begin
                    state_d = state_q;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q == DCW'(PIPE_DELAY)) begin
                    state_d       = ST_CLEAR;
                    sweep_start_s = 1'b1;
                    frame_done_d  = ~aborted_q;
                    if (!aborted_q) begin
                        frame_cnt_d = frame_cnt_q + FCNT_WIDTH'(1'b1);
                    end else begin
                        frame_cnt_d = frame_cnt_q;
                    end
                end else begin
                    drain_cnt_d = drain_cnt_q + DCW'(1'b1);
                end
            end
            default: begin
                state_d       = ST_INIT_CLR;
                sweep_start_s = 1'b1;
            end
        endcase
    end

    // RAM port mux; ready follows the next state so it never offers a beat in DRAIN
    always_comb begin
        din_ready_d = (state_d == ST_IDLE) || (state_d == ST_STAT);
        if (is_sweep(state_q)) begin
            ram_we_d     = clr_busy_s;
            ram_addr_d   = clr_addr_s;
            ram_wdata_d  = 1'b0;
            clear_busy_d = clr_busy_s;
        end else if (is_fwd(state_q)) begin
            ram_we_d     = stat_write;
            ram_addr_d   = stat_addr;
            ram_wdata_d  = 1'b1;
            clear_busy_d = 1'b0;
        end else begin
            ram_we_d     = 1'b0;
            ram_addr_d   = ram_addr_q;
            ram_wdata_d  = 1'b0;
            clear_busy_d = 1'b0;
        end
    end

    // state and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_INIT_CLR;
            drain_cnt_q  <= {DCW{1'b0}};
            aborted_q    <= 1'b0;
            din_ready_q  <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_wdata_q  <= 1'b0;
            ram_addr_q   <= {DATA_WIDTH{1'b0}};
            clear_busy_q <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            frame_cnt_q  <= {FCNT_WIDTH{1'b0}};
        end else begin
            state_q      <= state_d;
            drain_cnt_q  <= drain_cnt_d;
            aborted_q    <= aborted_d;
            din_ready_q  <= din_ready_d;
            ram_we_q     <= ram_we_d;
            ram_wdata_q  <= ram_wdata_d;
            ram_addr_q   <= ram_addr_d;
            clear_busy_q <= clear_busy_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign din_ready  = din_ready_q;
    assign ram_we     = ram_we_q;
    assign ram_wdata  = ram_wdata_q;
    assign ram_addr   = ram_addr_q;
    assign clear_busy = clear_busy_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
    assign frame_cnt  = frame_cnt_q;

endmodule
